uart_tx_controller: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_controller.sv | 146 ++++++++++++++
 tb/tb_uart_tx_controller.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and oversampling ratio.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int unsigned OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: frames one byte per request (start, LSB-first data, optional parity,
// stop), timing each bit with the 16x baud tick.
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter int unsigned DBITS      = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             tick,
    input  logic             tx_start,
    input  logic [DBITS-1:0] tx_din,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done_tick
);

    localparam logic [4:0] S_LAST    = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBITS - 1);
    localparam logic       ODD_INV   = 1'(PARITY_ODD);

    state_t           r_state, w_state_next;
    logic [4:0]       r_s, w_s_next;
    logic [2:0]       r_n, w_n_next;
    logic [DBITS-1:0] r_shift, w_shift_next;
    logic             r_parity, w_parity_next;
    logic             r_tx, w_tx_next;
    logic             r_busy;
    logic             r_done, w_done_next;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state  <= IDLE;
            r_s      <= '0;
            r_n      <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_s      <= w_s_next;
            r_n      <= w_n_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
            r_busy   <= (w_state_next != IDLE);
            r_done   <= w_done_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_s_next      = r_s;
        w_n_next      = r_n;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_tx_next     = r_tx;
        w_done_next   = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                // A tick coinciding with acceptance is deliberately not counted.
                if (tx_start) begin
                    w_shift_next  = tx_din;
                    w_parity_next = (^tx_din) ^ ODD_INV;
                    w_s_next      = '0;
                    w_state_next  = START;
                    w_tx_next     = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (r_s == S_LAST) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = DATA;
                        w_tx_next    = r_shift[0];
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (r_s == S_LAST) begin
                        w_s_next     = '0;
                        w_shift_next = r_shift >> 1;
                        if (r_n == N_LAST) begin
                            if (PARITY_EN != 0) begin
                                w_state_next = PARITY;
                                w_tx_next    = r_parity;
                            end else begin
                                w_state_next = STOP;
                                w_tx_next    = 1'b1;
                            end
                        end else begin
                            w_n_next  = r_n + 3'd1;
                            w_tx_next = r_shift[1];
                        end
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (r_s == S_LAST) begin
                        w_s_next     = '0;
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            STOP: begin
                w_tx_next = 1'b1;
                if (tick) begin
                    if (r_s == STOP_LAST) begin
                        w_s_next     = '0;
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    assign tx           = r_tx;
    assign tx_busy      = r_busy;
    assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller: four configurations, a tick-counting line decoder and a
// scoreboard of expected frames.
module tb_uart_tx_controller;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         start_ok;
        bit         stop_ok;
        bit         busy_ok;
        int         ticks;
        int         clks;
    } rx_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         ticks;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] tx_start = '0;
    logic [7:0] tx_din = '0;
    logic [3:0] w_tx, w_busy, w_done;

    int checks = 0;
    int errors = 0;
    bit tick_en = 1'b1;
    int tick_cnt = 0;
    int mon_sel = 0;
    int spurious = 0;

    bit         m_active = 1'b0;
    int         m_cnt = 0;
    int         m_clk = 0;
    logic [7:0] m_data;
    logic       m_par;
    bit         m_start_ok, m_stop_ok, m_busy_ok;

    rx_t  rx_q[$];
    exp_t exp_q[$];

    initial forever #5 clk = ~clk;

    // 0: 8N1, 1: even parity, 2: odd parity, 3: two stop bits
    uart_tx_controller #(.DBITS(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_8n1 (
        .clk_100MHz(clk), .reset(reset), .tick(tick), .tx_start(tx_start[0]), .tx_din(tx_din),
        .tx(w_tx[0]), .tx_busy(w_busy[0]), .tx_done_tick(w_done[0]));
    uart_tx_controller #(.DBITS(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_even (
        .clk_100MHz(clk), .reset(reset), .tick(tick), .tx_start(tx_start[1]), .tx_din(tx_din),
        .tx(w_tx[1]), .tx_busy(w_busy[1]), .tx_done_tick(w_done[1]));
    uart_tx_controller #(.DBITS(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_odd (
        .clk_100MHz(clk), .reset(reset), .tick(tick), .tx_start(tx_start[2]), .tx_din(tx_din),
        .tx(w_tx[2]), .tx_busy(w_busy[2]), .tx_done_tick(w_done[2]));
    uart_tx_controller #(.DBITS(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_2sb (
        .clk_100MHz(clk), .reset(reset), .tick(tick), .tx_start(tx_start[3]), .tx_din(tx_din),
        .tx(w_tx[3]), .tx_busy(w_busy[3]), .tx_done_tick(w_done[3]));

    function automatic bit cfg_pen(input int sel);
        return (sel == 1) || (sel == 2);
    endfunction

    function automatic int cfg_sb(input int sel);
        return (sel == 3) ? 32 : 16;
    endfunction

    function automatic logic model_par(input logic [7:0] d, input bit odd);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return ((ones % 2) == 1) ^ odd;
    endfunction

    // Line decoder plus tick source (M=4), both on the falling edge.
    initial begin
        bit   consumed;
        int   pen_bits, bidx;
        logic t, b, d;
        rx_t  r;
        forever begin
            @(negedge clk);
            consumed = tick;
            t = w_tx[mon_sel];
            b = w_busy[mon_sel];
            d = w_done[mon_sel];
            pen_bits = cfg_pen(mon_sel) ? 1 : 0;
            if (reset) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (d) spurious++;
                if (t === 1'b0) begin
                    m_active = 1'b1; m_cnt = 0; m_clk = 0; m_data = '0; m_par = 1'b0;
                    m_start_ok = 1'b1; m_stop_ok = 1'b1; m_busy_ok = 1'b1;
                end
            end else begin
                m_clk++;
                if (consumed) begin
                    m_cnt++;
                    if ((m_cnt % 16) == 8 && m_cnt < 16 * (9 + pen_bits)) begin
                        bidx = m_cnt / 16;
                        if (bidx == 0) begin
                            if (t !== 1'b0) m_start_ok = 1'b0;
                        end else if (bidx <= 8) begin
                            m_data[bidx-1] = t;
                        end else begin
                            m_par = t;
                        end
                    end
                end
                if (m_cnt >= 16 * (9 + pen_bits) && t !== 1'b1) m_stop_ok = 1'b0;
                if (!d && b !== 1'b1) m_busy_ok = 1'b0;
                if (d) begin
                    r.data = m_data; r.par = m_par; r.start_ok = m_start_ok;
                    r.stop_ok = m_stop_ok; r.busy_ok = m_busy_ok; r.ticks = m_cnt; r.clks = m_clk;
                    rx_q.push_back(r);
                    m_active = 1'b0;
                end
            end
            if (tick_en) begin
                tick = (tick_cnt == 3);
                tick_cnt = (tick_cnt + 1) % 4;
            end else begin
                tick = 1'b0;
            end
        end
    end

    task automatic send(input int idx, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        tx_din = d;
        tx_start[idx] = 1'b1;
        e.data = d;
        e.par = model_par(d, idx == 2);
        e.ticks = 16 * (9 + (cfg_pen(idx) ? 1 : 0)) + cfg_sb(idx);
        exp_q.push_back(e);
        @(negedge clk);
        tx_start[idx] = 1'b0;
    endtask

    task automatic wait_frame(output rx_t r, output exp_t e, output bit got);
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (rx_q.size() > 0 && exp_q.size() > 0) got = 1'b1;
        end
        if (got) begin
            r = rx_q.pop_front();
            e = exp_q.pop_front();
        end
    endtask

    task automatic wait_cnt(input int target, output bit got);
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (m_active && m_cnt >= target) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_tx[i] !== 1'b1) begin
                errors++; $display("FAIL reset_tx dut%0d got %b exp 1", i, w_tx[i]);
            end
            checks++;
            if (w_busy[i] !== 1'b0) begin
                errors++; $display("FAIL reset_busy dut%0d got %b exp 0", i, w_busy[i]);
            end
            checks++;
            if (w_done[i] !== 1'b0) begin
                errors++; $display("FAIL reset_done dut%0d got %b exp 0", i, w_done[i]);
            end
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] pats[2];
        rx_t  r;
        exp_t e;
        bit   got;
        pats[0] = 8'h55;
        pats[1] = 8'hC3;
        mon_sel = 0;
        for (int p = 0; p < 2; p++) begin
            send(0, pats[p]);
            checks++;
            if (w_tx[0] !== 1'b0 || w_busy[0] !== 1'b1) begin
                errors++; $display("FAIL basic_accept tx/busy got %b%b exp 01", w_tx[0], w_busy[0]);
            end
            wait_frame(r, e, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL basic_frame got timeout exp frame %h", pats[p]);
            end else begin
                checks++;
                if (r.data !== e.data) begin
                    errors++; $display("FAIL basic_data got %h exp %h", r.data, e.data);
                end
                checks++;
                if (!(r.start_ok && r.stop_ok && r.busy_ok)) begin
                    errors++;
                    $display("FAIL basic_framing got start/stop/busy %b%b%b exp 111",
                             r.start_ok, r.stop_ok, r.busy_ok);
                end
                checks++;
                if (r.ticks != e.ticks) begin
                    errors++; $display("FAIL basic_ticks got %0d exp %0d", r.ticks, e.ticks);
                end
                checks++;
                if (r.clks < 636 || r.clks > 644) begin
                    errors++; $display("FAIL basic_clks got %0d exp 640+-4", r.clks);
                end
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] pats[2];
        rx_t  r;
        exp_t e;
        bit   got;
        pats[0] = 8'h07;
        pats[1] = 8'hB4;
        for (int sel = 1; sel <= 2; sel++) begin
            mon_sel = sel;
            for (int p = 0; p < 2; p++) begin
                send(sel, pats[p]);
                wait_frame(r, e, got);
                checks++;
                if (!got) begin
                    errors++; $display("FAIL parity_frame dut%0d got timeout exp frame", sel);
                end else begin
                    checks++;
                    if (r.data !== e.data || r.par !== e.par) begin
                        errors++;
                        $display("FAIL parity_bits dut%0d got %h/%b exp %h/%b",
                                 sel, r.data, r.par, e.data, e.par);
                    end
                    checks++;
                    if (r.ticks != e.ticks || !r.stop_ok) begin
                        errors++;
                        $display("FAIL parity_len dut%0d got %0d ticks stop %b exp %0d stop 1",
                                 sel, r.ticks, r.stop_ok, e.ticks);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rx_t  r;
        exp_t e;
        bit   got, seen;
        mon_sel = 0;
        send(0, 8'h5A);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (w_done[0] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL b2b_done got timeout exp done pulse");
        end else begin
            tx_din = 8'hA3;
            tx_start[0] = 1'b1;
            e.data = 8'hA3; e.par = 1'b0; e.ticks = 160;
            exp_q.push_back(e);
            @(negedge clk);
            tx_start[0] = 1'b0;
            checks++;
            if (w_tx[0] !== 1'b0 || w_busy[0] !== 1'b1) begin
                errors++; $display("FAIL b2b_restart tx/busy got %b%b exp 01", w_tx[0], w_busy[0]);
            end
        end
        for (int f = 0; f < 2; f++) begin
            wait_frame(r, e, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL b2b_frame%0d got timeout exp frame", f);
            end else begin
                checks++;
                if (r.data !== e.data || r.ticks != e.ticks || !r.stop_ok) begin
                    errors++;
                    $display("FAIL b2b_data%0d got %h/%0d exp %h/%0d", f, r.data, r.ticks,
                             e.data, e.ticks);
                end
            end
        end
    endtask

    task automatic test_ignore_busy();
        rx_t  r;
        exp_t e;
        bit   got, saw_low;
        int   sp0;
        mon_sel = 0;
        send(0, 8'h96);
        wait_cnt(50, got);
        @(negedge clk);
        tx_din = 8'h69;
        tx_start[0] = 1'b1;
        @(negedge clk);
        tx_start[0] = 1'b0;
        wait_frame(r, e, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL ignore_frame got timeout exp frame 96");
        end else begin
            checks++;
            if (r.data !== e.data || r.ticks != e.ticks) begin
                errors++; $display("FAIL ignore_data got %h/%0d exp %h/%0d", r.data, r.ticks,
                                   e.data, e.ticks);
            end
        end
        sp0 = spurious;
        saw_low = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0) saw_low = 1'b1;
        end
        checks++;
        if (saw_low || rx_q.size() != 0 || spurious != sp0) begin
            errors++;
            $display("FAIL ignore_no_second got activity %b frames %0d dones %0d exp none",
                     saw_low, rx_q.size(), spurious - sp0);
        end
    endtask

    task automatic test_reset_mid_frame();
        rx_t  r;
        exp_t e;
        bit   got, saw_done;
        mon_sel = 0;
        send(0, 8'h3C);
        wait_cnt(84, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL rst_reach_bit4 got timeout exp data bit 4");
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (w_tx[0] !== 1'b1 || w_busy[0] !== 1'b0 || w_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort tx/busy/done got %b%b%b exp 100", w_tx[0], w_busy[0],
                     w_done[0]);
        end
        reset = 1'b0;
        exp_q.delete(exp_q.size() - 1);
        saw_done = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (w_done[0] !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || rx_q.size() != 0) begin
            errors++; $display("FAIL rst_no_done got done %b frames %0d exp 0 0", saw_done,
                               rx_q.size());
        end
        send(0, 8'h81);
        wait_frame(r, e, got);
        checks++;
        if (!got || r.data !== e.data || r.ticks != e.ticks || !r.stop_ok) begin
            errors++; $display("FAIL rst_resend got %h/%0d (seen %b) exp %h/%0d", r.data,
                               r.ticks, got, e.data, e.ticks);
        end
    endtask

    task automatic test_stop_hold();
        rx_t  r;
        exp_t e;
        bit   got, changed;
        logic tx_hold;
        int   cnt_hold;
        mon_sel = 3;
        send(3, 8'hC5);
        wait_cnt(53, got);
        @(negedge clk);
        tick_en = 1'b0;
        repeat (2) @(negedge clk);
        tx_hold = w_tx[3];
        cnt_hold = m_cnt;
        changed = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (w_tx[3] !== tx_hold || w_busy[3] !== 1'b1) changed = 1'b1;
        end
        checks++;
        if (changed || m_cnt != cnt_hold) begin
            errors++; $display("FAIL hold_freeze got change %b cnt %0d exp no change cnt %0d",
                               changed, m_cnt, cnt_hold);
        end
        tick_en = 1'b1;
        wait_frame(r, e, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL hold_frame got timeout exp frame c5");
        end else begin
            checks++;
            if (r.data !== e.data || !r.start_ok || !r.busy_ok) begin
                errors++; $display("FAIL hold_data got %h exp %h", r.data, e.data);
            end
            checks++;
            if (r.ticks != e.ticks || !r.stop_ok) begin
                errors++; $display("FAIL sb32_len got %0d ticks stop %b exp %0d stop 1",
                                   r.ticks, r.stop_ok, e.ticks);
            end
            checks++;
            if (r.clks < 800) begin
                errors++; $display("FAIL hold_stretch got %0d clks exp >= 800", r.clks);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        test_stop_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
